// File: rtl/core_m_seq.sv
// core_m_seq: multi-cycle sequencer for core_m (PC, IR, ibus/dbus handshakes, commit).
// Define PERF_CNT_EN to add 64-bit perf_cycle / perf_instret counters.
module core_m_seq #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] PC_RST_VEC = XLEN'(32'h8000_0000),
  parameter int              BUS_TMO    = 255
) (
  input  logic            clk,
  input  logic            rst_b,
  output logic            ibus_req_valid,
  input  logic            ibus_req_ready,
  output logic [XLEN-1:0] ibus_req_addr,
  input  logic            ibus_rsp_valid,
  input  logic [XLEN-1:0] ibus_rsp_data,
  output logic            dbus_req_valid,
  input  logic            dbus_req_ready,
  output logic            dbus_req_wen,
  input  logic            dbus_rsp_valid,
  input  logic            dec_mem_read,
  input  logic            dec_mem_write,
  input  logic            dec_rd_write,
  input  logic            dec_ebreak,
  input  logic            pc_branch,
  input  logic [XLEN-1:0] target_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] inst,
  output logic            rf_we,
  output logic            rd_sel_mem,
  output logic            halt,
  output logic            bus_err
`ifdef PERF_CNT_EN
  ,
  output logic [63:0]     perf_cycle,
  output logic [63:0]     perf_instret
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_FWAIT,
    S_EXEC,
    S_MEM,
    S_MWAIT,
    S_HALT,
    S_ERR
  } state_t;

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
  localparam logic [31:0] TMO_LAST = 32'(BUS_TMO - 1);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            ivld_q, ivld_d;
  logic            dvld_q, dvld_d;
  logic            halt_q, halt_d;
  logic            err_q, err_d;
  logic            sel_q, sel_d;
  logic            commit, busy, tmo;
  logic [XLEN-1:0] pc_inc;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    commit  = 1'b0;
    pc_inc  = pc_q + XLEN'(4);
    // the first cycle after reset has FETCH but no request out yet
    busy = ((state_q == S_FETCH) && ivld_q)
        || (state_q inside {S_FWAIT, S_MEM, S_MWAIT});
    tmo = (BUS_TMO != 0) && busy && (cnt_q == TMO_LAST);
    unique case (state_q)
      S_FETCH: begin
        if (ivld_q && ibus_req_ready) state_d = S_FWAIT;
        else if (tmo)                 state_d = S_ERR;
      end
      S_FWAIT: begin
        if (ibus_rsp_valid) begin
          inst_d  = ibus_rsp_data;
          state_d = S_EXEC;
        end else if (tmo) begin
          state_d = S_ERR;
        end
      end
      S_EXEC: begin
        if (dec_ebreak) begin
          state_d = S_HALT;
        end else if (dec_mem_read || dec_mem_write) begin
          state_d = S_MEM;
        end else begin
          commit  = 1'b1;
          pc_d    = pc_branch ? target_pc : pc_inc;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (dbus_req_ready) state_d = S_MWAIT;
        else if (tmo)       state_d = S_ERR;
      end
      S_MWAIT: begin
        if (dbus_rsp_valid) begin
          commit  = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else if (tmo) begin
          state_d = S_ERR;
        end
      end
      default: ;
    endcase
    cnt_d  = (busy && state_d == state_q) ? cnt_q + 32'd1 : '0;
    ivld_d = state_d == S_FETCH;
    dvld_d = state_d == S_MEM;
    halt_d = state_d == S_HALT;
    err_d  = state_d == S_ERR;
    sel_d  = state_d inside {S_MEM, S_MWAIT};
    rf_we  = commit & dec_rd_write & ~dec_mem_write;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_FETCH;
      pc_q    <= PC_RST_VEC;
      inst_q  <= NOP;
      cnt_q   <= '0;
      ivld_q  <= 1'b0;
      dvld_q  <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      ivld_q  <= ivld_d;
      dvld_q  <= dvld_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
    end
  end

  assign ibus_req_valid = ivld_q;
  assign ibus_req_addr  = pc_q;
  assign dbus_req_valid = dvld_q;
  assign dbus_req_wen   = dvld_q & dec_mem_write;
  assign pc             = pc_q;
  assign inst           = inst_q;
  assign rd_sel_mem     = sel_q;
  assign halt           = halt_q;
  assign bus_err        = err_q;

`ifdef PERF_CNT_EN
  logic [63:0] cyc_q, cyc_d;
  logic [63:0] ret_q, ret_d;

  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    if (!(state_q inside {S_HALT, S_ERR})) cyc_d = cyc_q + 64'd1;
    if (commit) ret_d = ret_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign perf_cycle   = cyc_q;
  assign perf_instret = ret_q;
`endif

endmodule

// File: tb/tb_core_m_seq.sv
// tb_core_m_seq: randomized bus/decode stimulus for core_m_seq,
// checked against an instruction-level model of PC flow, commits and latency.
module tb_core_m_seq;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [2:0]  K_ALU  = 3'd0;
  localparam logic [2:0]  K_LD   = 3'd1;
  localparam logic [2:0]  K_ST   = 3'd2;
  localparam logic [2:0]  K_BR   = 3'd3;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        ibus_req_ready = 1'b0;
  logic        ibus_rsp_valid = 1'b0;
  logic [31:0] ibus_rsp_data = '0;
  logic        dbus_req_ready = 1'b0;
  logic        dbus_rsp_valid = 1'b0;
  logic        ibus_req_valid, dbus_req_valid, dbus_req_wen;
  logic        rf_we, rd_sel_mem, halt, bus_err;
  logic [31:0] ibus_req_addr, pc, inst, target_pc;
  logic        dec_mem_read, dec_mem_write, dec_rd_write;
  logic        dec_ebreak, pc_branch;
`ifdef PERF_CNT_EN
  logic [63:0] perf_cycle, perf_instret;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_pc;

  always #5 clk = ~clk;

  // toy IDU/EXU: kind in [10:8], rd-write in [11], target in [31:16]
  assign dec_ebreak    = inst == EBREAK;
  assign dec_mem_read  = !dec_ebreak && inst[10:8] == K_LD;
  assign dec_mem_write = !dec_ebreak && inst[10:8] == K_ST;
  assign pc_branch     = !dec_ebreak && inst[10:8] == K_BR;
  assign dec_rd_write  = !dec_ebreak && inst[11];
  assign target_pc     = RST_PC | {14'd0, inst[31:16], 2'b00};

  core_m_seq #(.BUS_TMO(8)) dut (
    .clk(clk), .rst_b(rst_b),
    .ibus_req_valid(ibus_req_valid), .ibus_req_ready(ibus_req_ready),
    .ibus_req_addr(ibus_req_addr), .ibus_rsp_valid(ibus_rsp_valid),
    .ibus_rsp_data(ibus_rsp_data), .dbus_req_valid(dbus_req_valid),
    .dbus_req_ready(dbus_req_ready), .dbus_req_wen(dbus_req_wen),
    .dbus_rsp_valid(dbus_rsp_valid), .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write), .dec_rd_write(dec_rd_write),
    .dec_ebreak(dec_ebreak), .pc_branch(pc_branch),
    .target_pc(target_pc), .pc(pc), .inst(inst), .rf_we(rf_we),
    .rd_sel_mem(rd_sel_mem), .halt(halt), .bus_err(bus_err)
`ifdef PERF_CNT_EN
    , .perf_cycle(perf_cycle), .perf_instret(perf_instret)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    bit          stable;
    int          acc;
    int          nwe;
    int          we_cyc;
    logic        sel_we;
    bit          sel_ok;
    bit          dreq;
    logic        wen;
    int          rsp_cyc;
    int          drsp_cyc;
    int          halt_cyc;
    int          cyc;
  } obs_t;

  function automatic logic [31:0] mk(input logic [2:0] k, input logic rdw,
                                     input logic [15:0] tgt);
    return {tgt, 4'h0, rdw, k, 8'h33};
  endfunction

  task automatic idle_inputs();
    ibus_req_ready = 1'b0;
    ibus_rsp_valid = 1'b0;
    ibus_rsp_data  = 32'hDEAD_BEEF;
    dbus_req_ready = 1'b0;
    dbus_rsp_valid = 1'b0;
  endtask

  // Plays ibus/dbus for one instruction starting at a FETCH cycle; returns observations
  task automatic run_inst(input logic [31:0] w, input int iw, input int rw,
                          input int dw, input int sw, input bit junk,
                          output obs_t o);
    int c, ph, wc, rc, dc, sc;
    bit seen, in_mem;
    c = 0; ph = 0; wc = 0; rc = 0; dc = 0; sc = 0; seen = 0;
    o.addr = '0; o.stable = 1; o.acc = 0; o.nwe = 0; o.we_cyc = -1;
    o.sel_we = 0; o.sel_ok = 1; o.dreq = 0; o.wen = 0; o.rsp_cyc = -1;
    o.drsp_cyc = -1; o.halt_cyc = -1; o.cyc = -1;
    while (1) begin
      if (c >= 100) begin
        n_cmp++; n_bad++;
        $display("FAIL budget: instruction %h not finished in %0d cycles", w, c);
        o.cyc = c;
        break;
      end
      c++;
      idle_inputs();
      in_mem = 0;
      if (ph >= 2 && (ibus_req_valid || halt || bus_err)) begin
        if (halt) o.halt_cyc = c;
        o.cyc = c - 1;
        break;
      end
      case (ph)
        0: begin
          if (ibus_req_valid) begin
            if (!seen) begin
              seen = 1;
              o.addr = ibus_req_addr;
            end else if (ibus_req_addr !== o.addr) begin
              o.stable = 0;
            end
            if (wc >= iw) begin
              ibus_req_ready = 1'b1;
              ph = 1;
            end else if (junk) begin
              ibus_rsp_valid = 1'($urandom_range(0, 1));
              ibus_rsp_data  = $urandom;
            end
            wc++;
          end else if (seen) begin
            o.stable = 0;
          end
        end
        1: begin
          if (junk) ibus_req_ready = 1'($urandom_range(0, 1));
          if (rc >= rw) begin
            ibus_rsp_valid = 1'b1;
            ibus_rsp_data  = w;
            o.rsp_cyc = c;
            ph = 2;
          end
          rc++;
        end
        2: begin
          if (junk) ibus_req_ready = 1'($urandom_range(0, 1));
          if (dbus_req_valid) begin
            in_mem = 1;
            o.dreq = 1;
            o.wen  = dbus_req_wen;
            if (dc >= dw) begin
              dbus_req_ready = 1'b1;
              ph = 3;
            end
            dc++;
          end else if (junk) begin
            dbus_rsp_valid = 1'($urandom_range(0, 1));
          end
        end
        default: begin
          in_mem = 1;
          if (junk) dbus_req_ready = 1'($urandom_range(0, 1));
          if (sc >= sw) begin
            dbus_rsp_valid = 1'b1;
            o.drsp_cyc = c;
            ph = 2;
          end
          sc++;
        end
      endcase
      #1;
      if (ibus_req_valid && ibus_req_ready) o.acc++;
      if (rf_we) begin
        o.nwe++;
        o.we_cyc = c;
        o.sel_we = rd_sel_mem;
      end
      if (rd_sel_mem !== in_mem) o.sel_ok = 0;
      @(posedge clk);
      #1;
    end
    idle_inputs();
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    model_pc = RST_PC;
  endtask

  task automatic test_reset();
    #2 rst_b = 1'b0;
    #1;
    n_cmp++;
    if (pc !== RST_PC || inst !== NOP) begin
      n_bad++;
      $display("FAIL reset_pc_ir: pc=%h inst=%h want %h %h", pc, inst, RST_PC, NOP);
    end
    n_cmp++;
    if ({ibus_req_valid, dbus_req_valid, rf_we, halt, bus_err, rd_sel_mem} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctl: iv=%b dv=%b we=%b halt=%b err=%b sel=%b want all 0",
               ibus_req_valid, dbus_req_valid, rf_we, halt, bus_err, rd_sel_mem);
    end
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    model_pc = RST_PC;
  endtask

  task automatic test_alu_zero_wait();
    obs_t o;
    run_inst(mk(K_ALU, 1'b1, 16'h0), 0, 0, 0, 0, 0, o);
    n_cmp++;
    if (o.addr !== 32'h8000_0000 || o.nwe != 1 || o.we_cyc != 3) begin
      n_bad++;
      $display("FAIL addi: addr=%h nwe=%0d we_cyc=%0d want 80000000 1 3",
               o.addr, o.nwe, o.we_cyc);
    end
    run_inst(mk(K_ALU, 1'b0, 16'h0), 0, 0, 0, 0, 0, o);
    n_cmp++;
    if (o.addr !== 32'h8000_0004 || o.nwe != 0 || o.cyc != 3) begin
      n_bad++;
      $display("FAIL nop: addr=%h nwe=%0d cyc=%0d want 80000004 0 3",
               o.addr, o.nwe, o.cyc);
    end
    model_pc = 32'h8000_0008;
  endtask

  task automatic test_fetch_stall();
    obs_t o;
    logic [31:0] w;
    w = mk(K_ALU, 1'b1, 16'h1234);
    run_inst(w, 4, 1, 0, 0, 1, o);
    n_cmp++;
    if (!o.stable || o.addr !== model_pc || o.acc != 1) begin
      n_bad++;
      $display("FAIL fetch_stall: stable=%b addr=%h acc=%0d want 1 %h 1",
               o.stable, o.addr, o.acc, model_pc);
    end
    n_cmp++;
    if (inst !== w || o.cyc != 8) begin
      n_bad++;
      $display("FAIL stall_ir: inst=%h cyc=%0d want %h 8", inst, o.cyc, w);
    end
    model_pc = model_pc + 32'd4;
  endtask

  task automatic test_load();
    obs_t o;
    for (int i = 0; i < 4 && model_pc != 32'h8000_0010; i++) begin
      run_inst(mk(K_ALU, 1'b0, 16'h0), 0, 0, 0, 0, 0, o);
      model_pc = model_pc + 32'd4;
    end
    run_inst(mk(K_LD, 1'b1, 16'h0), 0, 0, 0, 2, 0, o);
    n_cmp++;
    if (o.addr !== 32'h8000_0010 || o.nwe != 1 || o.we_cyc != o.drsp_cyc
        || o.sel_we !== 1'b1 || o.wen !== 1'b0) begin
      n_bad++;
      $display("FAIL load: addr=%h nwe=%0d we@%0d rsp@%0d sel=%b wen=%b",
               o.addr, o.nwe, o.we_cyc, o.drsp_cyc, o.sel_we, o.wen);
    end
    n_cmp++;
    if (ibus_req_addr !== 32'h8000_0014 || !o.sel_ok || o.cyc != 7) begin
      n_bad++;
      $display("FAIL load_next: addr=%h sel_ok=%b cyc=%0d want 80000014 1 7",
               ibus_req_addr, o.sel_ok, o.cyc);
    end
    model_pc = 32'h8000_0014;
  endtask

  task automatic test_store_branch();
    obs_t o;
    run_inst(mk(K_ST, 1'b1, 16'h0), 0, 0, 1, 1, 1, o);
    n_cmp++;
    if (o.nwe != 0 || o.wen !== 1'b1 || !o.dreq || o.acc != 1) begin
      n_bad++;
      $display("FAIL store: nwe=%0d wen=%b dreq=%b acc=%0d want 0 1 1 1",
               o.nwe, o.wen, o.dreq, o.acc);
    end
    model_pc = model_pc + 32'd4;
    run_inst(mk(K_BR, 1'b0, 16'h0040), 0, 0, 0, 0, 0, o);
    n_cmp++;
    if (ibus_req_addr !== 32'h8000_0100 || o.nwe != 0) begin
      n_bad++;
      $display("FAIL branch: next=%h nwe=%0d want 80000100 0", ibus_req_addr, o.nwe);
    end
    model_pc = 32'h8000_0100;
  endtask

  task automatic test_random();
    obs_t o;
    logic [2:0]  k;
    logic        rdw, mem;
    logic [15:0] tgt;
    int iw, rw, dw, sw, exp_we, exp_cyc, exp_at;
    for (int i = 0; i < 40; i++) begin
      k   = 3'($urandom_range(0, 3));
      rdw = 1'($urandom_range(0, 1));
      tgt = 16'($urandom);
      iw = $urandom_range(0, 3); rw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3); sw = $urandom_range(0, 3);
      mem = (k == K_LD) || (k == K_ST);
      run_inst(mk(k, rdw, tgt), iw, rw, dw, sw, 1, o);
      exp_we  = (k != K_ST && rdw) ? 1 : 0;
      exp_cyc = iw + rw + 3 + (mem ? dw + sw + 2 : 0);
      exp_at  = mem ? o.drsp_cyc : o.rsp_cyc + 1;
      n_cmp++;
      if (o.addr !== model_pc || !o.stable || o.acc != 1) begin
        n_bad++;
        $display("FAIL rnd%0d_fetch: addr=%h stable=%b acc=%0d want %h 1 1",
                 i, o.addr, o.stable, o.acc, model_pc);
      end
      n_cmp++;
      if (o.nwe != exp_we || (exp_we == 1 && (o.we_cyc != exp_at
          || o.sel_we !== (k == K_LD)))) begin
        n_bad++;
        $display("FAIL rnd%0d_we: kind=%0d nwe=%0d at %0d sel=%b want %0d at %0d",
                 i, k, o.nwe, o.we_cyc, o.sel_we, exp_we, exp_at);
      end
      n_cmp++;
      if (o.dreq !== mem || (mem && o.wen !== (k == K_ST)) || !o.sel_ok) begin
        n_bad++;
        $display("FAIL rnd%0d_dbus: kind=%0d dreq=%b wen=%b sel_ok=%b",
                 i, k, o.dreq, o.wen, o.sel_ok);
      end
      n_cmp++;
      if (o.cyc != exp_cyc) begin
        n_bad++;
        $display("FAIL rnd%0d_lat: cycles=%0d want %0d", i, o.cyc, exp_cyc);
      end
      model_pc = (k == K_BR) ? (RST_PC | {14'd0, tgt, 2'b00}) : model_pc + 32'd4;
    end
  endtask

  task automatic test_halt();
    obs_t o;
    int   nreq;
    run_inst(EBREAK, 1, 1, 0, 0, 1, o);
    n_cmp++;
    if (o.halt_cyc != o.rsp_cyc + 2 || o.nwe != 0 || o.dreq) begin
      n_bad++;
      $display("FAIL halt: halt@%0d rsp@%0d nwe=%0d dreq=%b want halt@rsp+2 0 0",
               o.halt_cyc, o.rsp_cyc, o.nwe, o.dreq);
    end
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      ibus_req_ready = 1'b1;
      if (ibus_req_valid) nreq++;
      @(posedge clk);
      #1;
    end
    idle_inputs();
    n_cmp++;
    if (nreq != 0 || pc !== model_pc || halt !== 1'b1) begin
      n_bad++;
      $display("FAIL halt_hold: reqs=%0d pc=%h halt=%b want 0 %h 1",
               nreq, pc, halt, model_pc);
    end
  endtask

  task automatic test_timeout();
    int nv;
    nv = 0;
    for (int i = 0; i < 20 && !bus_err; i++) begin
      if (ibus_req_valid) nv++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (nv != 8 || bus_err !== 1'b1 || ibus_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout: valid_cycles=%0d err=%b iv=%b want 8 1 0",
               nv, bus_err, ibus_req_valid);
    end
    ibus_req_ready = 1'b1;
    ibus_rsp_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    idle_inputs();
    n_cmp++;
    if (pc !== model_pc || inst !== NOP || bus_err !== 1'b1 || ibus_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL err_sticky: pc=%h inst=%h err=%b iv=%b want %h %h 1 0",
               pc, inst, bus_err, ibus_req_valid, model_pc, NOP);
    end
  endtask

  task automatic test_reset_mid_fwait();
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      run_inst(mk(K_ALU, 1'b1, 16'h0), $urandom_range(0, 2), 0, 0, 0, 0, o);
      model_pc = model_pc + 32'd4;
    end
    ibus_req_ready = 1'b1;
    @(posedge clk);
    #1;
    ibus_req_ready = 1'b0;
    #3 rst_b = 1'b0;
    #1;
    n_cmp++;
    if (pc !== RST_PC || inst !== NOP || ibus_req_valid !== 1'b0
        || dbus_req_valid !== 1'b0 || rf_we !== 1'b0 || bus_err !== 1'b0) begin
      n_bad++;
      $display("FAIL async_rst: pc=%h inst=%h iv=%b dv=%b we=%b err=%b",
               pc, inst, ibus_req_valid, dbus_req_valid, rf_we, bus_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    model_pc = RST_PC;
    run_inst(mk(K_ALU, 1'b1, 16'h0), 0, 0, 0, 0, 0, o);
    n_cmp++;
    if (o.addr !== RST_PC || o.nwe != 1) begin
      n_bad++;
      $display("FAIL restart: addr=%h nwe=%0d want %h 1", o.addr, o.nwe, RST_PC);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu_zero_wait();
    test_fetch_stall();
    test_load();
    test_store_branch();
    test_random();
    test_halt();
    do_reset();
    test_timeout();
    do_reset();
    test_reset_mid_fwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
